// File: rtl/sha256_compress.sv
// Iterative SHA-256 compression: one round per clock over a pre-expanded
// 64-word schedule, then a final feed-forward add of the chaining value.
module sha256_compress (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2047:0] block_in,
    input  logic [255:0]  hash_in,
    output logic          busy,
    output logic          done,
    output logic [255:0]  hash_out
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    state_t        state_q;
    logic [5:0]    t_q;
    logic [2047:0] sched_q;
    logic [255:0]  hin_q;
    logic [31:0]   a_q, b_q, c_q, d_q, e_q, f_q, g_q, h_q;
    logic          busy_q, done_q;
    logic [255:0]  hash_q;

    logic [31:0]   w_t, ch, maj, t1, t2, a_d, e_d;

    // The schedule shifts up one word per round, so W[t] is always the top word.
    assign w_t = sched_q[2047:2016];
    assign ch  = (e_q & f_q) ^ (~e_q & g_q);
    assign maj = (a_q & b_q) ^ (a_q & c_q) ^ (b_q & c_q);
    assign t1  = h_q + bsig1(e_q) + ch + K[t_q] + w_t;
    assign t2  = bsig0(a_q) + maj;
    assign a_d = t1 + t2;
    assign e_d = d_q + t1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= '0;
            sched_q <= '0;
            hin_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            d_q     <= '0;
            e_q     <= '0;
            f_q     <= '0;
            g_q     <= '0;
            h_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hash_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sched_q <= block_in;
                        hin_q   <= hash_in;
                        a_q     <= hash_in[255:224];
                        b_q     <= hash_in[223:192];
                        c_q     <= hash_in[191:160];
                        d_q     <= hash_in[159:128];
                        e_q     <= hash_in[127:96];
                        f_q     <= hash_in[95:64];
                        g_q     <= hash_in[63:32];
                        h_q     <= hash_in[31:0];
                        t_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ROUND;
                    end
                end
                ROUND: begin
                    h_q     <= g_q;
                    g_q     <= f_q;
                    f_q     <= e_q;
                    e_q     <= e_d;
                    d_q     <= c_q;
                    c_q     <= b_q;
                    b_q     <= a_q;
                    a_q     <= a_d;
                    sched_q <= {sched_q[2015:0], 32'h0};
                    t_q     <= t_q + 6'd1;
                    if (t_q == 6'd63) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    hash_q <= {hin_q[255:224] + a_q, hin_q[223:192] + b_q,
                               hin_q[191:160] + c_q, hin_q[159:128] + d_q,
                               hin_q[127:96]  + e_q, hin_q[95:64]   + f_q,
                               hin_q[63:32]   + g_q, hin_q[31:0]    + h_q};
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hash_out = hash_q;

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress using known SHA-256 digests; the
// message schedule is expanded here from the padded 512-bit block.
module tb_sha256_compress;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2047:0] block_in;
    logic [255:0]  hash_in;
    logic          busy;
    logic          done;
    logic [255:0]  hash_out;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] H_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] H_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] H_TWO =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] M_TWO2  = {480'h0, 32'h000001c0};

    sha256_compress dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .block_in (block_in),
        .hash_in  (hash_in),
        .busy     (busy),
        .done     (done),
        .hash_out (hash_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [2047:0] expand(input logic [511:0] msg);
        logic [31:0]   w [64];
        logic [2047:0] r;
        logic [31:0]   s0, s1;
        for (int i = 0; i < 16; i++) w[i] = msg[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0   = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1   = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        for (int i = 0; i < 64; i++) r[2047-32*i -: 32] = w[i];
        return r;
    endfunction

    // Starts a job and waits (bounded) for done; latency is -1 on timeout.
    task automatic run_job(input logic [2047:0] blk, input logic [255:0] hin,
                           output logic [255:0] res, output int lat,
                           output logic busy_after, output logic done_after);
        block_in = blk;
        hash_in  = hin;
        start    = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        busy_after = busy;
        lat        = -1;
        res        = '0;
        for (int i = 1; i <= 150; i++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = i;
                res = hash_out;
                break;
            end
        end
        @(posedge clk); #1;
        done_after = done;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        start    = 1'b0;
        block_in = '0;
        hash_in  = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if (hash_out !== 256'h0) begin failures++; $display("[TB] FAIL reset_hash: got %h expected 0", hash_out); end
        rst = 1'b0;
    endtask

    task automatic test_empty();
        logic [255:0] res;
        int lat;
        logic ba, da;
        run_job(expand(M_EMPTY), IV, res, lat, ba, da);
        checks++; if (ba !== 1'b1) begin failures++; $display("[TB] FAIL empty_busy: got %b expected 1", ba); end
        checks++; if (lat != 65) begin failures++; $display("[TB] FAIL empty_latency: got %0d expected 65", lat); end
        checks++; if (res !== H_EMPTY) begin failures++; $display("[TB] FAIL empty_hash: got %h expected %h", res, H_EMPTY); end
        checks++; if (da !== 1'b0) begin failures++; $display("[TB] FAIL empty_done_pulse: got %b expected 0", da); end
    endtask

    task automatic test_abc();
        logic [255:0] res;
        int lat;
        logic ba, da;
        run_job(expand(M_ABC), IV, res, lat, ba, da);
        checks++; if (lat != 65) begin failures++; $display("[TB] FAIL abc_latency: got %0d expected 65", lat); end
        checks++; if (res !== H_ABC) begin failures++; $display("[TB] FAIL abc_hash: got %h expected %h", res, H_ABC); end
    endtask

    task automatic test_two_block();
        logic [255:0] r1, r2;
        int lat1, lat2;
        logic ba, da;
        run_job(expand(M_TWO1), IV, r1, lat1, ba, da);
        run_job(expand(M_TWO2), r1, r2, lat2, ba, da);
        checks++; if (lat2 != 65) begin failures++; $display("[TB] FAIL two_latency: got %0d expected 65", lat2); end
        checks++; if (r2 !== H_TWO) begin failures++; $display("[TB] FAIL two_hash: got %h expected %h", r2, H_TWO); end
    endtask

    task automatic test_start_while_busy();
        logic [255:0] res = '0;
        int dones = 0;
        int lat = -1;
        block_in = expand(M_ABC);
        hash_in  = IV;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                res = hash_out;
                lat = cyc;
            end
            if (cyc == 10) begin
                start    = 1'b1;
                block_in = expand(M_EMPTY);
                hash_in  = ~IV;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (dones != 1) begin failures++; $display("[TB] FAIL busy_start_dones: got %0d expected 1", dones); end
        checks++; if (lat != 65) begin failures++; $display("[TB] FAIL busy_start_latency: got %0d expected 65", lat); end
        checks++; if (res !== H_ABC) begin failures++; $display("[TB] FAIL busy_start_hash: got %h expected %h", res, H_ABC); end
    endtask

    task automatic test_isolation();
        logic [255:0] res = '0;
        int lat = -1;
        block_in = expand(M_EMPTY);
        hash_in  = IV;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            for (int k = 0; k < 64; k++) block_in[32*k +: 32] = $urandom;
            for (int k = 0; k < 8; k++) hash_in[32*k +: 32] = $urandom;
            @(posedge clk); #1;
            if (done) begin
                lat = cyc;
                res = hash_out;
                break;
            end
        end
        checks++; if (lat != 65) begin failures++; $display("[TB] FAIL isolation_latency: got %0d expected 65", lat); end
        checks++; if (res !== H_EMPTY) begin failures++; $display("[TB] FAIL isolation_hash: got %h expected %h", res, H_EMPTY); end
    endtask

    task automatic test_reset_mid_run();
        logic [255:0] res;
        int lat;
        int dones = 0;
        logic ba, da;
        block_in = expand(M_ABC);
        hash_in  = IV;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL midreset_done: got %b expected 0", done); end
        checks++; if (hash_out !== 256'h0) begin failures++; $display("[TB] FAIL midreset_hash: got %h expected 0", hash_out); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int cyc = 0; cyc < 70; cyc++) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++; if (dones != 0) begin failures++; $display("[TB] FAIL midreset_no_done: got %0d expected 0", dones); end
        run_job(expand(M_EMPTY), IV, res, lat, ba, da);
        checks++; if (lat != 65) begin failures++; $display("[TB] FAIL midreset_rerun_latency: got %0d expected 65", lat); end
        checks++; if (res !== H_EMPTY) begin failures++; $display("[TB] FAIL midreset_rerun_hash: got %h expected %h", res, H_EMPTY); end
    endtask

    task automatic test_back_to_back();
        logic [255:0] r1 = '0, r2 = '0;
        int lat1 = -1, lat2 = -1;
        logic busy_next, done_next;
        block_in = expand(M_ABC);
        hash_in  = IV;
        start    = 1'b1;
        @(posedge clk); #1;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                lat1 = cyc;
                r1   = hash_out;
                break;
            end
        end
        // Start is still high, so this edge should launch the second job.
        @(posedge clk); #1;
        busy_next = busy;
        done_next = done;
        for (int cyc = 1; cyc <= 150; cyc++) begin
            @(posedge clk); #1;
            if (done) begin
                lat2  = cyc;
                r2    = hash_out;
                start = 1'b0;
                break;
            end
        end
        start = 1'b0;
        checks++; if (lat1 != 65) begin failures++; $display("[TB] FAIL b2b_latency1: got %0d expected 65", lat1); end
        checks++; if (r1 !== H_ABC) begin failures++; $display("[TB] FAIL b2b_hash1: got %h expected %h", r1, H_ABC); end
        checks++; if (busy_next !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy_rise: got %b expected 1", busy_next); end
        checks++; if (done_next !== 1'b0) begin failures++; $display("[TB] FAIL b2b_done_drop: got %b expected 0", done_next); end
        checks++; if (lat2 != 65) begin failures++; $display("[TB] FAIL b2b_latency2: got %0d expected 65", lat2); end
        checks++; if (r2 !== H_ABC) begin failures++; $display("[TB] FAIL b2b_hash2: got %h expected %h", r2, H_ABC); end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_empty();
        test_abc();
        test_two_block();
        test_start_while_busy();
        test_isolation();
        test_reset_mid_run();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
